// File: rtl/ram_arbiter_2.sv
// Two-port round-robin arbiter in front of a single-port RAM; grant and RAM drive are combinational.
// Read data returns one cycle after grant; a losing port is stalled by holding its req until gnt.
module ram_arbiter_2 #(
   parameter int SIZE  = 8,
   parameter int DEPTH = 256,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            a_req,
   input  logic            a_we,
   input  logic [AW-1:0]   a_addr,
   input  logic [SIZE-1:0] a_wdata,
   output logic            a_gnt,
   output logic            a_rvalid,
   output logic [SIZE-1:0] a_rdata,
   input  logic            b_req,
   input  logic            b_we,
   input  logic [AW-1:0]   b_addr,
   input  logic [SIZE-1:0] b_wdata,
   output logic            b_gnt,
   output logic            b_rvalid,
   output logic [SIZE-1:0] b_rdata,
   output logic [AW-1:0]   ram_address,
   output logic [SIZE-1:0] ram_write_data,
   output logic            ram_write_en,
   input  logic [SIZE-1:0] ram_read_data
);

   localparam logic [0:0] WIN_A = 1'b0;
   localparam logic [0:0] WIN_B = 1'b1;

   logic [0:0] last_winner_q, last_winner_d;
   logic       a_rvalid_q, a_rvalid_d;
   logic       b_rvalid_q, b_rvalid_d;

   always_comb begin
      a_gnt = 1'b0;
      b_gnt = 1'b0;
      if (!rst) begin
         // Under contention the port that did not win last time goes first.
         if (a_req && (!b_req || last_winner_q == WIN_B)) begin
            a_gnt = 1'b1;
         end else if (b_req) begin
            b_gnt = 1'b1;
         end
      end

      ram_address    = a_addr;
      ram_write_data = a_wdata;
      ram_write_en   = 1'b0;
      if (a_gnt) begin
         ram_write_en = a_we;
      end else if (b_gnt) begin
         ram_address    = b_addr;
         ram_write_data = b_wdata;
         ram_write_en   = b_we;
      end

      last_winner_d = last_winner_q;
      if (a_gnt) begin
         last_winner_d = WIN_A;
      end else if (b_gnt) begin
         last_winner_d = WIN_B;
      end

      a_rvalid_d = a_gnt & ~a_we;
      b_rvalid_d = b_gnt & ~b_we;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_winner_q <= WIN_B;
         a_rvalid_q    <= 1'b0;
         b_rvalid_q    <= 1'b0;
      end else begin
         last_winner_q <= last_winner_d;
         a_rvalid_q    <= a_rvalid_d;
         b_rvalid_q    <= b_rvalid_d;
      end
   end

   // Gating with rst drops a read response that would land in a reset cycle.
   assign a_rvalid = a_rvalid_q & ~rst;
   assign b_rvalid = b_rvalid_q & ~rst;
   assign a_rdata  = ram_read_data;
   assign b_rdata  = ram_read_data;

endmodule

// File: tb/tb_ram_arbiter_2.sv
// Bench for ram_arbiter_2: directed scenarios plus random traffic against a RAM model and read scoreboard.
module tb_ram_arbiter_2;
   localparam int SIZE = 8;
   localparam int DEPTH = 256;
   localparam int AW = 8;

   logic clk, rst;
   logic a_req, a_we, a_gnt, a_rvalid, b_req, b_we, b_gnt, b_rvalid;
   logic [AW-1:0] a_addr, b_addr, ram_address;
   logic [SIZE-1:0] a_wdata, b_wdata, a_rdata, b_rdata;
   logic [SIZE-1:0] ram_write_data, ram_read_data;
   logic ram_write_en;

   typedef struct packed {
      logic port;               // 0 = A, 1 = B
      logic [SIZE-1:0] data;
   } rd_exp_t;

   rd_exp_t sb_q[$];
   logic [SIZE-1:0] ram [DEPTH];
   logic [SIZE-1:0] shadow [DEPTH];
   logic [SIZE-1:0] ram_rd_q;
   logic m_lw;                  // model last winner, 1 = B
   int n_cmp = 0;
   int n_bad = 0;

   ram_arbiter_2 #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
      .ram_address(ram_address), .ram_write_data(ram_write_data),
      .ram_write_en(ram_write_en), .ram_read_data(ram_read_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_write_en) ram[ram_address] <= ram_write_data;
      ram_rd_q <= ram[ram_address];
   end
   assign ram_read_data = ram_rd_q;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
      b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
   endtask

   task automatic do_reset();
      rst = 1; idle();
      tick();
      rst = 0;
      sb_q.delete();
      m_lw = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1;
      a_req = 1; a_we = 1; a_addr = 8'd9; b_req = 1; b_we = 1;
      tick(); tick();
      n_cmp++; if (a_gnt !== 1'b0) begin n_bad++; $display("FAIL rst_a_gnt got=%b exp=0", a_gnt); end
      n_cmp++; if (b_gnt !== 1'b0) begin n_bad++; $display("FAIL rst_b_gnt got=%b exp=0", b_gnt); end
      n_cmp++; if (ram_write_en !== 1'b0) begin n_bad++; $display("FAIL rst_we got=%b exp=0", ram_write_en); end
      rst = 0; idle(); #1;
      n_cmp++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin n_bad++; $display("FAIL rst_rvalid got=%b%b exp=00", a_rvalid, b_rvalid); end
      sb_q.delete(); m_lw = 1'b1;
   endtask

   task automatic test_write_read();
      rd_exp_t e;
      do_reset();
      a_req = 1; a_we = 1; a_addr = 8'd5; a_wdata = 8'h3C; #1;
      n_cmp++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin n_bad++; $display("FAIL wr_gnt got=%b%b exp=10", a_gnt, b_gnt); end
      n_cmp++; if (ram_write_en !== 1'b1) begin n_bad++; $display("FAIL wr_we got=%b exp=1", ram_write_en); end
      n_cmp++; if (ram_address !== 8'd5 || ram_write_data !== 8'h3C) begin n_bad++; $display("FAIL wr_addr_data got=%h/%h exp=05/3c", ram_address, ram_write_data); end
      shadow[5] = 8'h3C;
      tick();
      idle(); b_req = 1; b_we = 0; b_addr = 8'd5; #1;
      n_cmp++; if (a_rvalid !== 1'b0) begin n_bad++; $display("FAIL wr_no_rvalid got=%b exp=0", a_rvalid); end
      n_cmp++; if (b_gnt !== 1'b1 || a_gnt !== 1'b0) begin n_bad++; $display("FAIL rd_gnt got=%b%b exp=01", a_gnt, b_gnt); end
      n_cmp++; if (ram_write_en !== 1'b0 || ram_address !== 8'd5) begin n_bad++; $display("FAIL rd_ram got=%b/%h exp=0/05", ram_write_en, ram_address); end
      sb_q.push_back('{port: 1'b1, data: shadow[5]});
      tick();
      idle(); #1;
      e = sb_q.pop_front();
      n_cmp++; if (b_rvalid !== 1'b1 || a_rvalid !== 1'b0) begin n_bad++; $display("FAIL raw_rvalid got=%b%b exp=01", a_rvalid, b_rvalid); end
      n_cmp++; if (b_rdata !== e.data) begin n_bad++; $display("FAIL raw_rdata got=%h exp=%h", b_rdata, e.data); end
      tick();
      n_cmp++; if (b_rvalid !== 1'b0) begin n_bad++; $display("FAIL raw_rvalid_once got=%b exp=0", b_rvalid); end
   endtask

   task automatic test_contention();
      rd_exp_t e;
      logic exp_a_rv, exp_b_rv;
      do_reset();
      for (int k = 0; k < 5; k++) begin
         if (k < 4) begin
            a_req = 1; b_req = 1; a_we = 0; b_we = 0; a_addr = 8'd1; b_addr = 8'd2;
         end else idle();
         #1;
         exp_a_rv = (sb_q.size() > 0) && (sb_q[0].port == 1'b0);
         exp_b_rv = (sb_q.size() > 0) && (sb_q[0].port == 1'b1);
         n_cmp++; if (a_rvalid !== exp_a_rv || b_rvalid !== exp_b_rv) begin n_bad++; $display("FAIL rr_rvalid k=%0d got=%b%b exp=%b%b", k, a_rvalid, b_rvalid, exp_a_rv, exp_b_rv); end
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_cmp++; if ((e.port ? b_rdata : a_rdata) !== e.data) begin n_bad++; $display("FAIL rr_rdata k=%0d got=%h exp=%h", k, e.port ? b_rdata : a_rdata, e.data); end
         end
         if (k < 4) begin
            n_cmp++; if (a_gnt !== (k % 2 == 0) || b_gnt !== (k % 2 == 1)) begin n_bad++; $display("FAIL rr_order k=%0d got=%b%b exp=%b%b", k, a_gnt, b_gnt, k % 2 == 0, k % 2 == 1); end
            sb_q.push_back('{port: (k % 2 == 1), data: shadow[(k % 2 == 1) ? 2 : 1]});
         end
         tick();
      end
   endtask

   task automatic test_single_hold();
      do_reset();
      for (int k = 0; k < 3; k++) begin
         idle(); a_req = 1; a_we = 1; a_addr = 8'd3; a_wdata = 8'h70 + 8'(k); #1;
         n_cmp++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin n_bad++; $display("FAIL hold_gnt k=%0d got=%b%b exp=10", k, a_gnt, b_gnt); end
         n_cmp++; if (a_rvalid !== 1'b0) begin n_bad++; $display("FAIL hold_no_rvalid k=%0d got=%b exp=0", k, a_rvalid); end
         shadow[3] = 8'h70 + 8'(k);
         tick();
      end
      a_req = 1; a_we = 0; b_req = 1; b_we = 0; b_addr = 8'd3; #1;
      n_cmp++; if (b_gnt !== 1'b1 || a_gnt !== 1'b0) begin n_bad++; $display("FAIL hold_b_first got=%b%b exp=01", a_gnt, b_gnt); end
      n_cmp++; if (ram_address !== 8'd3 || ram_write_en !== 1'b0) begin n_bad++; $display("FAIL hold_b_ram got=%h/%b exp=03/0", ram_address, ram_write_en); end
      tick();
      b_req = 0; #1;
      n_cmp++; if (b_rvalid !== 1'b1 || b_rdata !== shadow[3]) begin n_bad++; $display("FAIL hold_b_data got=%b/%h exp=1/%h", b_rvalid, b_rdata, shadow[3]); end
      n_cmp++; if (a_gnt !== 1'b1) begin n_bad++; $display("FAIL hold_a_next got=%b exp=1", a_gnt); end
      tick();
      idle(); tick();
   endtask

   task automatic test_reset_cancel();
      do_reset();
      a_req = 1; a_we = 0; a_addr = 8'd1; b_req = 1; b_we = 0; b_addr = 8'd2; #1;
      n_cmp++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin n_bad++; $display("FAIL rc_first got=%b%b exp=10", a_gnt, b_gnt); end
      tick();
      rst = 1; a_we = 1; b_we = 1; #1;
      n_cmp++; if (a_rvalid !== 1'b0) begin n_bad++; $display("FAIL rc_rvalid got=%b exp=0", a_rvalid); end
      n_cmp++; if (a_gnt !== 1'b0 || b_gnt !== 1'b0 || ram_write_en !== 1'b0) begin n_bad++; $display("FAIL rc_quiet got=%b%b%b exp=000", a_gnt, b_gnt, ram_write_en); end
      tick();
      rst = 0; idle(); #1;
      n_cmp++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin n_bad++; $display("FAIL rc_after got=%b%b exp=00", a_rvalid, b_rvalid); end
      tick();
      sb_q.delete(); m_lw = 1'b1;
   endtask

   task automatic test_random();
      rd_exp_t e;
      logic exp_a, exp_b, exp_a_rv, exp_b_rv;
      logic [AW-1:0] g_addr;
      do_reset();
      for (int k = 0; k < 400; k++) begin
         a_req = 1'($urandom_range(0, 1)); a_we = 1'($urandom_range(0, 1));
         b_req = 1'($urandom_range(0, 1)); b_we = 1'($urandom_range(0, 1));
         a_addr = 8'($urandom_range(0, 7)); b_addr = 8'($urandom_range(0, 7));
         a_wdata = 8'($urandom); b_wdata = 8'($urandom);
         #1;
         exp_a_rv = (sb_q.size() > 0) && (sb_q[0].port == 1'b0);
         exp_b_rv = (sb_q.size() > 0) && (sb_q[0].port == 1'b1);
         n_cmp++; if (a_rvalid !== exp_a_rv || b_rvalid !== exp_b_rv) begin n_bad++; $display("FAIL rnd_rvalid k=%0d got=%b%b exp=%b%b", k, a_rvalid, b_rvalid, exp_a_rv, exp_b_rv); end
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_cmp++; if ((e.port ? b_rdata : a_rdata) !== e.data) begin n_bad++; $display("FAIL rnd_rdata k=%0d got=%h exp=%h", k, e.port ? b_rdata : a_rdata, e.data); end
         end
         n_cmp++; if ((a_gnt & b_gnt) !== 1'b0) begin n_bad++; $display("FAIL rnd_both_gnt k=%0d got=%b%b exp=not 11", k, a_gnt, b_gnt); end
         exp_a = a_req && (!b_req || m_lw);
         exp_b = b_req && !exp_a;
         n_cmp++; if (a_gnt !== exp_a || b_gnt !== exp_b) begin n_bad++; $display("FAIL rnd_gnt k=%0d got=%b%b exp=%b%b", k, a_gnt, b_gnt, exp_a, exp_b); end
         if (exp_a || exp_b) begin
            g_addr = exp_a ? a_addr : b_addr;
            n_cmp++; if (ram_address !== g_addr || ram_write_en !== (exp_a ? a_we : b_we)) begin n_bad++; $display("FAIL rnd_ram k=%0d got=%h/%b exp=%h/%b", k, ram_address, ram_write_en, g_addr, exp_a ? a_we : b_we); end
            if (exp_a ? a_we : b_we) begin
               n_cmp++; if (ram_write_data !== (exp_a ? a_wdata : b_wdata)) begin n_bad++; $display("FAIL rnd_wdata k=%0d got=%h exp=%h", k, ram_write_data, exp_a ? a_wdata : b_wdata); end
               shadow[g_addr] = exp_a ? a_wdata : b_wdata;
            end else begin
               sb_q.push_back('{port: exp_b, data: shadow[g_addr]});
            end
            m_lw = exp_b;
         end else begin
            n_cmp++; if (ram_write_en !== 1'b0 || ram_address !== a_addr) begin n_bad++; $display("FAIL rnd_idle_ram k=%0d got=%b/%h exp=0/%h", k, ram_write_en, ram_address, a_addr); end
         end
         tick();
      end
      idle(); #1;
      n_cmp++; if (sb_q.size() > 0 && ((sb_q[0].port ? b_rvalid : a_rvalid) !== 1'b1 || (sb_q[0].port ? b_rdata : a_rdata) !== sb_q[0].data)) begin n_bad++; $display("FAIL rnd_last got rvalid a=%b b=%b data=%h exp=%h", a_rvalid, b_rvalid, ram_read_data, sb_q[0].data); end
      tick();
   endtask

   initial begin
      rst = 1; idle();
      for (int i = 0; i < DEPTH; i++) begin
         ram[i] = 8'(i) ^ 8'hA5;
         shadow[i] = 8'(i) ^ 8'hA5;
      end
      m_lw = 1'b1;
      test_reset();
      test_write_read();
      test_contention();
      test_single_hold();
      test_reset_cancel();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
